// File: rtl/pipe_scheduler.sv
// pipe_scheduler: game FSM plus scroll, pipe/coin ring and score bookkeeping for a side-scroller.
// Rev 1.0
`default_nettype none

module pipe_scheduler #(
  parameter int NUM_PIPES    = 5,
  parameter int PIPE_SPACING = 160,
  parameter int SCORE_MAX    = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       frame_tick,
  input  logic       collide,
  input  logic       coin_hit,
  input  logic [1:0] speed,
  output logic [2:0] pipe_idx,
  output logic [2:0] coin_idx,
  output logic [7:0] scroll_off,
  output logic       advance,
  output logic       running,
  output logic       game_over,
  output logic [9:0] score
);

  localparam logic [8:0]  SPACING  = 9'(PIPE_SPACING);
  localparam logic [10:0] SMAX     = 11'(SCORE_MAX);
  localparam logic [2:0]  LAST_IDX = 3'(NUM_PIPES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t state, state_next;

  logic        clear;
  logic        do_scroll;
  logic        do_coin;
  logic [1:0]  eff_speed;
  logic [8:0]  sum;
  logic        wrap;
  logic        wrap_pend;
  logic [2:0]  pipe_next;
  logic [10:0] score_sum;
  logic [9:0]  score_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // collide dominates everything in RUN; coin_hit still scores on the cycle RUN enters PAUSE
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    do_scroll  = 1'b0;
    do_coin    = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_next = RUN;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (collide) begin
          state_next = OVER;
        end else if (pause) begin
          state_next = PAUSE;
          do_coin    = coin_hit;
        end else begin
          do_scroll = frame_tick;
          do_coin   = coin_hit;
        end
      end
      PAUSE: begin
        if (!pause) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign eff_speed = (speed == 2'd0) ? 2'd1 : speed;
  assign sum       = {1'b0, scroll_off} + {7'd0, eff_speed};
  assign wrap      = do_scroll && (sum >= SPACING);
  assign pipe_next = (pipe_idx == LAST_IDX) ? 3'd0 : pipe_idx + 3'd1;

  assign score_sum  = {1'b0, score} + {10'd0, wrap} + (do_coin ? 11'd5 : 11'd0);
  assign score_next = (score_sum > SMAX) ? SMAX[9:0] : score_sum[9:0];

  // coin_idx follows pipe_idx one cycle after a wrap, independent of the FSM, so a
  // wrap just before a collision is still delivered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_idx   <= 3'd0;
      coin_idx   <= 3'd0;
      scroll_off <= 8'd0;
      score      <= 10'd0;
      wrap_pend  <= 1'b0;
      advance    <= 1'b0;
    end else begin
      advance   <= wrap_pend;
      wrap_pend <= wrap;
      if (wrap_pend) coin_idx <= pipe_idx;
      if (clear) begin
        pipe_idx   <= 3'd0;
        coin_idx   <= 3'd0;
        scroll_off <= 8'd0;
        score      <= 10'd0;
      end else begin
        if (do_scroll) scroll_off <= wrap ? 8'(sum - SPACING) : sum[7:0];
        if (wrap)      pipe_idx   <= pipe_next;
        score <= score_next;
      end
    end
  end

  assign running   = (state == RUN);
  assign game_over = (state == OVER);

endmodule

`default_nettype wire

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: directed and randomized checks of pipe_scheduler against a distance-based model.
// Rev 1.0
`default_nettype none

module tb_pipe_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, pause = 1'b0, frame_tick = 1'b0, collide = 1'b0, coin_hit = 1'b0;
  logic [1:0] speed = 2'd1;
  logic [2:0] pipe_idx, coin_idx;
  logic [7:0] scroll_off;
  logic       advance, running, game_over;
  logic [9:0] score;

  int tests = 0;
  int fails = 0;

  // Model: total distance travelled since start; everything else derives from it
  int         m_st;    // 0 idle, 1 run, 2 pause, 3 over
  int         m_dist;
  int         m_coins;
  logic [2:0] m_coin;
  logic       m_adv;
  logic       m_pend;

  pipe_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .frame_tick(frame_tick),
    .collide(collide), .coin_hit(coin_hit), .speed(speed), .pipe_idx(pipe_idx),
    .coin_idx(coin_idx), .scroll_off(scroll_off), .advance(advance), .running(running),
    .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] expv();
    int s;
    s = m_dist / 160 + 5 * m_coins;
    if (s > 999) s = 999;
    return {m_st == 1, m_st == 3, 3'((m_dist / 160) % 5), m_coin, 8'(m_dist % 160), m_adv, 10'(s)};
  endfunction

  function automatic logic [26:0] outv();
    return {running, game_over, pipe_idx, coin_idx, scroll_off, advance, score};
  endfunction

  task automatic model_reset();
    m_st = 0; m_dist = 0; m_coins = 0; m_coin = 3'd0; m_adv = 1'b0; m_pend = 1'b0;
  endtask

  // Advance the model by one clock with the current inputs, then clock the DUT
  task automatic cycle();
    logic [2:0] cur_pipe;
    int e, old;
    cur_pipe = 3'((m_dist / 160) % 5);
    m_adv = m_pend;
    if (m_pend) m_coin = cur_pipe;
    m_pend = 1'b0;
    case (m_st)
      0, 3: if (start) begin m_st = 1; m_dist = 0; m_coins = 0; m_coin = 3'd0; end
      1: begin
        if (collide) m_st = 3;
        else if (pause) begin
          m_st = 2;
          if (coin_hit) m_coins++;
        end else begin
          if (coin_hit) m_coins++;
          if (frame_tick) begin
            e = (speed == 2'd0) ? 1 : int'(speed);
            old = m_dist / 160;
            m_dist += e;
            if (m_dist / 160 != old) m_pend = 1'b1;
          end
        end
      end
      2: if (!pause) m_st = 1;
      default: m_st = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    {start, pause, frame_tick, collide, coin_hit} = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic begin_game();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [1:0] spd);
    speed = spd; frame_tick = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    {start, pause, frame_tick, collide, coin_hit} = '0;
    reset = 1'b1;
    #2;
    tests++;
    if (outv() !== 27'd0) begin
      fails++; $display("FAIL reset_values: got %h expected 0", outv());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1; coin_hit = 1'b1; cycle();
      tests++;
      if (outv() !== 27'd0) begin
        fails++; $display("FAIL idle_hold: got %h expected 0", outv());
      end
    end
    {frame_tick, coin_hit} = '0;
  endtask

  task automatic test_wrap80();
    begin_game();
    tests++;
    if (running !== 1'b1 || score !== 10'd0) begin
      fails++; $display("FAIL start_run: running=%b score=%0d expected 1/0", running, score);
    end
    speed = 2'd2; frame_tick = 1'b1;
    for (int i = 0; i < 80; i++) begin
      cycle();
      tests++;
      if (outv() !== expv()) begin
        fails++; $display("FAIL wrap80_step%0d: got %h expected %h", i, outv(), expv());
      end
    end
    frame_tick = 1'b0;
    tests++;
    if (scroll_off !== 8'd0 || pipe_idx !== 3'd1 || advance !== 1'b0 || coin_idx !== 3'd0) begin
      fails++; $display("FAIL wrap80_edge: scroll=%0d pipe=%0d adv=%b coin=%0d expected 0/1/0/0",
                        scroll_off, pipe_idx, advance, coin_idx);
    end
    cycle();
    tests++;
    if (coin_idx !== 3'd1 || advance !== 1'b1 || score !== 10'd1) begin
      fails++; $display("FAIL wrap80_advance: coin=%0d adv=%b score=%0d expected 1/1/1",
                        coin_idx, advance, score);
    end
    cycle();
    tests++;
    if (advance !== 1'b0) begin
      fails++; $display("FAIL advance_single: got %b expected 0", advance);
    end
  endtask

  task automatic test_speed3();
    do_reset();
    begin_game();
    ticks(79, 2'd2);
    tests++;
    if (scroll_off !== 8'd158) begin
      fails++; $display("FAIL pre158: got %0d expected 158", scroll_off);
    end
    ticks(1, 2'd3);
    tests++;
    if (scroll_off !== 8'd1 || pipe_idx !== 3'd1) begin
      fails++; $display("FAIL speed3_wrap: scroll=%0d pipe=%0d expected 1/1", scroll_off, pipe_idx);
    end
    speed = 2'd3; frame_tick = 1'b1;
    for (int i = 0; i < 400 && m_dist / 160 < 5; i++) begin
      cycle();
      tests++;
      if (outv() !== expv()) begin
        fails++; $display("FAIL speed3_step%0d: got %h expected %h", i, outv(), expv());
      end
    end
    frame_tick = 1'b0;
    tests++;
    if (pipe_idx !== 3'd0 || m_dist / 160 != 5) begin
      fails++; $display("FAIL ring_wrap: pipe=%0d wraps=%0d expected 0/5", pipe_idx, m_dist / 160);
    end
    cycle();
    tests++;
    if (coin_idx !== 3'd0 || advance !== 1'b1) begin
      fails++; $display("FAIL coin_ring_wrap: coin=%0d adv=%b expected 0/1", coin_idx, advance);
    end
  endtask

  task automatic test_collide();
    logic [7:0] held_scroll;
    logic [9:0] held_score;
    ticks(7, 2'd1);
    coin_hit = 1'b1; cycle(); coin_hit = 1'b0;
    cycle();
    held_scroll = 8'(m_dist % 160);
    held_score  = 10'(m_dist / 160 + 5 * m_coins);
    collide = 1'b1; frame_tick = 1'b1; coin_hit = 1'b1;
    cycle();
    collide = 1'b0;
    tests++;
    if (game_over !== 1'b1 || running !== 1'b0 || scroll_off !== held_scroll || score !== held_score) begin
      fails++; $display("FAIL collide_priority: go=%b run=%b scroll=%0d score=%0d expected 1/0/%0d/%0d",
                        game_over, running, scroll_off, score, held_scroll, held_score);
    end
    for (int i = 0; i < 4; i++) cycle();
    frame_tick = 1'b0; coin_hit = 1'b0;
    tests++;
    if (outv() !== expv() || scroll_off !== held_scroll || score !== held_score) begin
      fails++; $display("FAIL over_ignores: got %h expected %h", outv(), expv());
    end
    begin_game();
    tests++;
    if (running !== 1'b1 || game_over !== 1'b0 || pipe_idx !== 3'd0 || coin_idx !== 3'd0 ||
        scroll_off !== 8'd0 || score !== 10'd0) begin
      fails++; $display("FAIL restart_clear: got %h expected %h", outv(), 27'h4000000);
    end
  endtask

  task automatic test_pause();
    logic [7:0] held;
    ticks(5, 2'd2);
    held = scroll_off;
    pause = 1'b1; frame_tick = 1'b1; speed = 2'd2;
    for (int i = 0; i < 10; i++) begin
      cycle();
      tests++;
      if (scroll_off !== held || running !== 1'b0 || game_over !== 1'b0) begin
        fails++; $display("FAIL pause_hold%0d: scroll=%0d run=%b expected %0d/0", i, scroll_off, running, held);
      end
    end
    pause = 1'b0; frame_tick = 1'b0;
    cycle();
    tests++;
    if (running !== 1'b1 || scroll_off !== held) begin
      fails++; $display("FAIL pause_resume: run=%b scroll=%0d expected 1/%0d", running, scroll_off, held);
    end
    ticks(1, 2'd2);
    tests++;
    if (scroll_off !== held + 8'd2) begin
      fails++; $display("FAIL resume_scroll: got %0d expected %0d", scroll_off, held + 8'd2);
    end
  endtask

  task automatic test_score_sat();
    do_reset();
    begin_game();
    coin_hit = 1'b1;
    for (int i = 0; i < 199; i++) cycle();
    coin_hit = 1'b0;
    ticks(80, 2'd2);
    tests++;
    if (score !== 10'd996) begin
      fails++; $display("FAIL score996: got %0d expected 996", score);
    end
    ticks(79, 2'd2);
    coin_hit = 1'b1; ticks(1, 2'd2); coin_hit = 1'b0;
    tests++;
    if (score !== 10'd999 || outv() !== expv()) begin
      fails++; $display("FAIL score_clamp: got %0d expected 999", score);
    end
    coin_hit = 1'b1; cycle(); coin_hit = 1'b0;
    tests++;
    if (score !== 10'd999) begin
      fails++; $display("FAIL score_hold: got %0d expected 999", score);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_game();
    ticks(80, 2'd2);
    reset = 1'b1;
    #1;
    tests++;
    if (outv() !== 27'd0) begin
      fails++; $display("FAIL async_abort: got %h expected 0", outv());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (advance !== 1'b0 || outv() !== 27'd0) begin
        fails++; $display("FAIL pend_discard%0d: got %h expected 0", i, outv());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    begin_game();
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom % 40) == 0;
      collide    = ($urandom % 120) == 0;
      if (($urandom % 12) == 0) pause = ~pause;
      frame_tick = ($urandom % 3) != 0;
      coin_hit   = ($urandom % 9) == 0;
      speed      = 2'($urandom);
      cycle();
      tests++;
      if (outv() !== expv()) begin
        fails++; $display("FAIL random%0d: got %h expected %h", i, outv(), expv());
      end
    end
    {start, pause, frame_tick, collide, coin_hit} = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap80();
    test_speed3();
    test_collide();
    test_pause();
    test_score_sat();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_scheduler.md
PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

Interface
REQ-001 Parameter NUM_PIPES, default 5, is the pipe/coin ring size; the index wraps 4->0.
REQ-002 Parameter PIPE_SPACING, default 160, is the scroll distance in pixels between successive pipes.
REQ-003 Parameter SCORE_MAX, default 999, is the score saturation value.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that begins a new game.
REQ-007 pause  in  1  level; a high level holds scrolling.
REQ-008 frame_tick  in  1  single-cycle pulse, once per video frame.
REQ-009 collide  in  1  level; the bird overlaps a pipe.
REQ-010 coin_hit  in  1  single-cycle pulse; a coin has been collected.
REQ-011 speed  in  2  scroll pixels per frame; a value of 0 is treated as 1.
REQ-012 pipe_idx  out  3  pipe rotation index, 0..4, drives the pipe-height table index.
REQ-013 coin_idx  out  3  coin rotation index, 0..4, drives the coin-height table index.
REQ-014 scroll_off  out  8  current scroll offset, 0..PIPE_SPACING-1.
REQ-015 advance  out  1  single-cycle pulse marking a pipe rotation and coin refresh.
REQ-016 running  out  1  high in state RUN.
REQ-017 game_over  out  1  high in state OVER.
REQ-018 score  out  10  game score, saturating at SCORE_MAX.

Function
REQ-019 FSM states SHALL be IDLE, RUN, PAUSE and OVER, with exactly one state active.
REQ-020 IDLE: start -> RUN; the same edge clears pipe_idx, coin_idx, scroll_off and score to 0.
REQ-021 OVER: start -> RUN with the same clearing as in IDLE; all other inputs are ignored.
REQ-022 RUN: collide=1 -> OVER; collide has priority over pause, frame_tick and coin_hit in the same cycle, and none of these has any effect in that cycle.
REQ-023 RUN: pause=1 with collide=0 -> PAUSE; a frame_tick in the same cycle is ignored.
REQ-024 PAUSE: pause=0 -> RUN; frame_tick, collide and coin_hit are ignored while in PAUSE.
REQ-025 start SHALL be ignored in RUN and PAUSE.
REQ-026 RUN with frame_tick=1: sum = scroll_off + eff_speed, computed 9 bits wide.
  - If sum < PIPE_SPACING: scroll_off <= sum.
  - Otherwise: scroll_off <= sum - PIPE_SPACING, pipe_idx <= (pipe_idx==4 ? 0 : pipe_idx+1), and a wrap is flagged.
REQ-027 coin_idx SHALL take the new pipe_idx value one cycle after a wrap, and advance SHALL be high in that same cycle only.
REQ-028 coin_idx therefore lags pipe_idx by exactly one cycle after each wrap; a consumer samples the coin height when advance=1.
REQ-029 Score rules:
  - +1 on each wrap.
  - +5 on coin_hit in RUN.
  - +6 when both occur in the same cycle.
  - The result SHALL clamp to SCORE_MAX, and no overflow past 10 bits is permitted.
REQ-030 A wrap pending at the cycle RUN->OVER (via collide) SHALL still deliver its delayed coin_idx update and advance pulse.
REQ-031 running and game_over SHALL be decoded from registered state, with no combinational path from the inputs.
REQ-032 Indices SHALL never leave the range 0..4; no index value 5..7 is reachable.

Reset
REQ-033 While reset=1, asynchronously: state=IDLE, pipe_idx=0, coin_idx=0, scroll_off=0, score=0, advance=0, running=0, game_over=0.
REQ-034 Reset asserted mid-game SHALL abort immediately, and any pending coin_idx update or advance pulse is discarded.
REQ-035 After reset deasserts, the block SHALL stay in IDLE until a start pulse arrives.

Verification
REQ-036 Reset, start, speed=2, 80 frame_ticks -> the 80th tick wraps: scroll_off=0, pipe_idx=1, next cycle coin_idx=1 and advance=1 for one cycle, score=1.
REQ-037 speed=3, scroll_off=158, frame_tick -> scroll_off=1, pipe_idx increments; 5 wraps from 0 -> pipe_idx returns to 0.
REQ-038 RUN, same cycle collide=1 + frame_tick + coin_hit -> OVER, game_over=1, scroll_off and score unchanged; then start -> RUN with all counters 0.
REQ-039 pause=1 for 10 frame_ticks -> scroll_off constant and running=0; pause=0 -> RUN resumes from the held offset.
REQ-040 score=996, coin_hit coincident with a wrap -> score=999; a further coin_hit keeps score=999.
REQ-041 reset pulse asserted in the cycle between a wrap and advance -> advance never asserts, and all outputs are at their reset values.
